// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: ownership states and
// requester identifiers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    FREE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } own_state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Ownership state that a locked acceptance by req_id moves into.
  function automatic own_state_e own_state_for(input logic req_id);
    return (req_id == REQ1) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_grant2.sv
// Combinational 2-way grant: a locked owner keeps the port while it is valid,
// otherwise round-robin on last_winner.
module rr_grant2
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_winner,
  input  own_state_e state,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if ((state == OWN0) && valid[REQ0]) begin
      grant = 2'b01;
    end else if ((state == OWN1) && valid[REQ1]) begin
      grant = 2'b10;
    end else if (valid == 2'b11) begin
      // Contention: the requester that did not win last time goes first.
      grant = (last_winner == REQ0) ? 2'b10 : 2'b01;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data memory between the load/store unit (rq0)
// and the debug/loader port (rq1); read data returns one cycle after accept.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rq0_valid,
  output logic                  rq0_ready,
  input  logic                  rq0_write,
  input  logic                  rq0_lock,
  input  logic [ADDR_WIDTH-1:0] rq0_addr,
  input  logic [DATA_WIDTH-1:0] rq0_wdata,
  output logic                  rs0_valid,
  output logic [DATA_WIDTH-1:0] rs0_rdata,
  input  logic                  rq1_valid,
  output logic                  rq1_ready,
  input  logic                  rq1_write,
  input  logic                  rq1_lock,
  input  logic [ADDR_WIDTH-1:0] rq1_addr,
  input  logic [DATA_WIDTH-1:0] rq1_wdata,
  output logic                  rs1_valid,
  output logic [DATA_WIDTH-1:0] rs1_rdata,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  own_state_e            state_q, state_d;
  logic                  last_winner_q, last_winner_d;
  logic [1:0]            raw_grant;
  logic [1:0]            gnt;
  logic                  accept;
  logic                  win_id;
  logic                  win_lock;
  logic                  win_write;

  logic                  rs0_vld_p1_q, rs0_vld_p1_d;
  logic                  rs1_vld_p1_q, rs1_vld_p1_d;
  logic [DATA_WIDTH-1:0] rs0_data_p1_q, rs0_data_p1_d;
  logic [DATA_WIDTH-1:0] rs1_data_p1_q, rs1_data_p1_d;

  rr_grant2 u_rr_grant2 (
    .valid       ({rq1_valid, rq0_valid}),
    .last_winner (last_winner_q),
    .state       (state_q),
    .grant       (raw_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FREE;
      last_winner_q <= REQ1;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
    end
  end

  // Ownership only survives a cycle in which the owner was accepted with lock.
  always_comb begin
    state_d       = FREE;
    last_winner_d = last_winner_q;
    if (accept) begin
      last_winner_d = win_id;
      state_d       = win_lock ? own_state_for(win_id) : FREE;
    end
  end

  // Grants are suppressed while reset is held so nothing reaches the memory.
  always_comb begin
    gnt       = raw_grant & {2{rst_n}};
    accept    = |gnt;
    win_id    = gnt[REQ1] ? REQ1 : REQ0;
    win_lock  = (win_id == REQ1) ? rq1_lock  : rq0_lock;
    win_write = (win_id == REQ1) ? rq1_write : rq0_write;
    rq0_ready = gnt[REQ0];
    rq1_ready = gnt[REQ1];
    mem_write = accept & win_write;
    mem_addr  = gnt[REQ1] ? rq1_addr : rq0_addr;
    mem_wdata = '0;
    if (gnt[REQ0]) begin
      mem_wdata = rq0_wdata;
    end else if (gnt[REQ1]) begin
      mem_wdata = rq1_wdata;
    end
  end

  // ---- p0 -> p1: capture combinational read data at the accept edge ----
  always_comb begin
    rs0_vld_p1_d  = gnt[REQ0] & ~rq0_write;
    rs1_vld_p1_d  = gnt[REQ1] & ~rq1_write;
    rs0_data_p1_d = rs0_vld_p1_d ? mem_rdata : rs0_data_p1_q;
    rs1_data_p1_d = rs1_vld_p1_d ? mem_rdata : rs1_data_p1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs0_vld_p1_q  <= 1'b0;
      rs1_vld_p1_q  <= 1'b0;
      rs0_data_p1_q <= '0;
      rs1_data_p1_q <= '0;
    end else begin
      rs0_vld_p1_q  <= rs0_vld_p1_d;
      rs1_vld_p1_q  <= rs1_vld_p1_d;
      rs0_data_p1_q <= rs0_data_p1_d;
      rs1_data_p1_q <= rs1_data_p1_d;
    end
  end

  assign rs0_valid = rs0_vld_p1_q;
  assign rs1_valid = rs1_vld_p1_q;
  assign rs0_rdata = rs0_data_p1_q;
  assign rs1_rdata = rs1_data_p1_q;

endmodule
